speech_playback_ctrl: RTL

Sequencer that turns keyboard commands into sample playback for the speech synthesizer. Decodes ASCII command codes (play/pause/forward/backward/restart) and walks a word-addressed flash region between START_ADDR and END_ADDR. Unpacks each 32-bit word into four 8-bit samples and hands one sample out per audio request. Sits between the PS/2 keyboard receiver, the flash read master port and the audio sample path.

---
 rtl/speech_pkg.sv | 35 +++
 rtl/speech_cmd_decode.sv | 38 +++
 rtl/speech_playback_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/speech_pkg.sv
// Shared types and constants for the speech playback sequencer.
// FSM states, keyboard command codes and sample-unpacking helper.
package speech_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IDX_W          = 2;
    localparam int unsigned WORD_W         = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        OUTPUT,
        NEXT,
        RESTART
    } state_t;

    localparam logic [7:0] CMD_PLAY_U    = 8'h45;
    localparam logic [7:0] CMD_PLAY_L    = 8'h65;
    localparam logic [7:0] CMD_PAUSE_U   = 8'h44;
    localparam logic [7:0] CMD_PAUSE_L   = 8'h64;
    localparam logic [7:0] CMD_FWD_U     = 8'h46;
    localparam logic [7:0] CMD_FWD_L     = 8'h66;
    localparam logic [7:0] CMD_BACK_U    = 8'h42;
    localparam logic [7:0] CMD_BACK_L    = 8'h62;
    localparam logic [7:0] CMD_RESTART_U = 8'h52;
    localparam logic [7:0] CMD_RESTART_L = 8'h72;

    // Byte idx of a flash word; byte 0 is bits 7:0.
    function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w,
                                             input logic [IDX_W-1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/speech_cmd_decode.sv
// Keyboard command decoder: holds play/pause, direction and pending restart.
// A restart code arriving in the same cycle as restart_clr stays pending.
module speech_cmd_decode
    import speech_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ready,
    input  logic [7:0] code,
    input  logic       restart_clr,
    output logic       playing,
    output logic       reverse,
    output logic       restart_pend
);

    always_ff @(posedge clk) begin
        if (reset) begin
            playing      <= 1'b0;
            reverse      <= 1'b0;
            restart_pend <= 1'b0;
        end else begin
            if (restart_clr) begin
                restart_pend <= 1'b0;
            end
            if (ready) begin
                case (code)
                    CMD_PLAY_U,    CMD_PLAY_L:    playing      <= 1'b1;
                    CMD_PAUSE_U,   CMD_PAUSE_L:   playing      <= 1'b0;
                    CMD_FWD_U,     CMD_FWD_L:     reverse      <= 1'b0;
                    CMD_BACK_U,    CMD_BACK_L:    reverse      <= 1'b1;
                    CMD_RESTART_U, CMD_RESTART_L: restart_pend <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/speech_playback_ctrl.sv
// Speech playback sequencer: walks the flash speech region word by word and
// hands out one 8-bit sample per audio request, under keyboard control.
module speech_playback_ctrl
    import speech_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(23'h07FFFF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic [7:0]        code,
    input  logic              audio_req,
    input  logic              flash_waitrequest,
    input  logic              flash_readdatavalid,
    input  logic [WORD_W-1:0] flash_readdata,
    output logic              flash_read,
    output logic [ADDR_W-1:0] flash_addr,
    output logic [7:0]        audio_sample,
    output logic              sample_strobe,
    output logic              playing,
    output logic              reverse
);

    state_t             state, state_d;
    logic               flash_read_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [WORD_W-1:0]  word, word_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic               word_rev, word_rev_d;
    logic [7:0]         sample_d;
    logic               strobe_d;
    logic               restart_pend;
    logic               restart_clr;
    logic               last_byte;

    speech_cmd_decode u_cmd_decode (
        .clk          (clk),
        .reset        (reset),
        .ready        (ready),
        .code         (code),
        .restart_clr  (restart_clr),
        .playing      (playing),
        .reverse      (reverse),
        .restart_pend (restart_pend)
    );

    // Word order is frozen at latch time so a direction change waits for the word boundary.
    assign last_byte = word_rev ? (idx == '0) : (idx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            flash_read    <= 1'b0;
            flash_addr    <= START_ADDR;
            word          <= '0;
            idx           <= '0;
            word_rev      <= 1'b0;
            audio_sample  <= '0;
            sample_strobe <= 1'b0;
        end else begin
            state         <= state_d;
            flash_read    <= flash_read_d;
            flash_addr    <= addr_d;
            word          <= word_d;
            idx           <= idx_d;
            word_rev      <= word_rev_d;
            audio_sample  <= sample_d;
            sample_strobe <= strobe_d;
        end
    end

    always_comb begin
        state_d      = state;
        flash_read_d = flash_read;
        addr_d       = flash_addr;
        word_d       = word;
        idx_d        = idx;
        word_rev_d   = word_rev;
        sample_d     = audio_sample;
        strobe_d     = 1'b0;
        restart_clr  = 1'b0;

        case (state)
            IDLE: begin
                if (restart_pend) begin
                    state_d = RESTART;
                end else if (playing) begin
                    state_d      = FETCH;
                    flash_read_d = 1'b1;
                end
            end
            // Read is held until accepted, regardless of pause or restart.
            FETCH: begin
                flash_read_d = 1'b1;
                if (flash_read && !flash_waitrequest) begin
                    flash_read_d = 1'b0;
                    state_d      = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (flash_readdatavalid) begin
                    if (restart_pend) begin
                        state_d = RESTART;
                    end else begin
                        word_d     = flash_readdata;
                        word_rev_d = reverse;
                        idx_d      = reverse ? IDX_W'(BYTES_PER_WORD - 1) : '0;
                        state_d    = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                if (restart_pend) begin
                    state_d = RESTART;
                end else if (audio_req && playing) begin
                    sample_d = word_byte(word, idx);
                    strobe_d = 1'b1;
                    idx_d    = word_rev ? idx - IDX_W'(1) : idx + IDX_W'(1);
                    if (last_byte) begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                if (reverse) begin
                    addr_d = (flash_addr == START_ADDR) ? END_ADDR : flash_addr - ADDR_W'(1);
                end else begin
                    addr_d = (flash_addr == END_ADDR) ? START_ADDR : flash_addr + ADDR_W'(1);
                end
                if (playing) begin
                    state_d      = FETCH;
                    flash_read_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RESTART: begin
                restart_clr = 1'b1;
                addr_d      = reverse ? END_ADDR : START_ADDR;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
